// File: rtl/umich_state_readback_if.sv
// Serial readback stream: one data bit per beat, LSB first, valid/ready handshake.
//   valid : beat present (master -> slave)
//   ready : slave accepts beat (slave -> master)
//   data  : serial data bit
//   last  : final beat of the snapshot
interface umich_state_readback_if;
  logic valid;
  logic ready;
  logic data;
  logic last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/umich_state_readback.sv
// Snapshots WIDTH register bits from a parallel state tap and streams them out serially,
// LSB first, over a valid/ready port. Used for debug dumps of mapped netlist registers.
//
// Optional feature macro: UMICH_READBACK_PARITY_EN
//   When defined, an extra final beat carries even parity (XOR of all captured bits),
//   computed at capture time. When undefined, no parity logic exists.
//
// Ports:
//   clocked_on  : clock, rising edge
//   clear       : asynchronous active-low reset
//   capture_req : snapshot request, honoured only while idle
//   state_in    : parallel state tap (WIDTH bits)
//   busy        : high while a snapshot is held, being shifted, or completing
//   done        : one-cycle pulse after the final beat is accepted
//   sout        : serial stream (master side of umich_state_readback_if)
module umich_state_readback #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                          clocked_on,
  input  logic                          clear,
  input  logic                          capture_req,
  input  logic [WIDTH-1:0]              state_in,
  output logic                          busy,
  output logic                          done,
  umich_state_readback_if.master        sout
);

`ifdef UMICH_READBACK_PARITY_EN
  localparam int unsigned Beats = WIDTH + 1;
`else
  localparam int unsigned Beats = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(WIDTH + 2);
  localparam logic [CntW-1:0] LastCnt = CntW'(Beats - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q;
  logic [Beats-1:0]  shadow_q;
  logic [Beats-1:0]  shadow_d;
  logic [CntW-1:0]   cnt_q;

  // Capture value: the parity bit, when present, sits above the data so it shifts out last.
  always_comb begin
    shadow_d = '0;
`ifdef UMICH_READBACK_PARITY_EN
    shadow_d = {^state_in, state_in};
`else
    shadow_d = state_in;
`endif
  end

  always_ff @(posedge clocked_on or negedge clear) begin
    if (!clear) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (capture_req) begin
            shadow_q <= shadow_d;
            cnt_q    <= '0;
            state_q  <= StShift;
          end
        end
        StShift: begin
          // valid is always high here, so ready alone marks a transfer.
          if (sout.ready) begin
            shadow_q <= shadow_q >> 1;
            if (cnt_q == LastCnt) begin
              cnt_q   <= '0;
              state_q <= StDone;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decode registered state only; ready never reaches valid combinationally.
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign sout.valid = (state_q == StShift);
  assign sout.data  = shadow_q[0];
  assign sout.last  = (state_q == StShift) && (cnt_q == LastCnt);

endmodule

// File: tb/tb_umich_state_readback.sv
module tb_umich_state_readback;

`ifdef UMICH_READBACK_PARITY_EN
  localparam bit ParEn  = 1'b1;
  localparam int Beats8 = 9;
  localparam int Beats2 = 3;
`else
  localparam bit ParEn  = 1'b0;
  localparam int Beats8 = 8;
  localparam int Beats2 = 2;
`endif

  typedef struct packed {
    logic data;
    logic last;
  } beat_t;

  logic       clk;
  logic       clear;
  logic       capture_req;
  logic [7:0] state_in;
  logic       busy;
  logic       done;
  logic       capture_req2;
  logic [1:0] state_in2;
  logic       busy2;
  logic       done2;

  umich_state_readback_if s1 ();
  umich_state_readback_if s2 ();

  umich_state_readback #(.WIDTH(8)) u_dut (
    .clocked_on  (clk),
    .clear       (clear),
    .capture_req (capture_req),
    .state_in    (state_in),
    .busy        (busy),
    .done        (done),
    .sout        (s1)
  );

  umich_state_readback #(.WIDTH(2)) u_dut2 (
    .clocked_on  (clk),
    .clear       (clear),
    .capture_req (capture_req2),
    .state_in    (state_in2),
    .busy        (busy2),
    .done        (done2),
    .sout        (s2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  beat_t q1[$];
  beat_t q2[$];
  int    exp_done1 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream for one WIDTH=8 snapshot; parity bit is passed hand-computed.
  task automatic push8(input logic [7:0] v, input logic par, input bit with_done);
    for (int i = 0; i < 8; i++) q1.push_back('{data: v[i], last: (i == 7) && !ParEn});
    if (ParEn) q1.push_back('{data: par, last: 1'b1});
    if (with_done) exp_done1++;
  endtask

  // Called at posedge+1 while the DUT is idle; capture happens on the next edge.
  task automatic capture8(input logic [7:0] v);
    state_in    = v;
    capture_req = 1'b1;
    @(posedge clk);
    #1 capture_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 100 && busy; c++) @(negedge clk);
    chk(name, 32'(busy), 32'd0);
  endtask

  // Monitor for the WIDTH=8 instance: scoreboard pops, backpressure stability, done pulses.
  initial begin
    logic  prev_stall;
    logic  prev_data;
    logic  prev_last;
    beat_t e;
    prev_stall = 1'b0;
    prev_data  = 1'b0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (clear) begin
        if (prev_stall) begin
          chk("hold valid", 32'(s1.valid), 32'd1);
          chk("hold data", 32'(s1.data), 32'(prev_data));
          chk("hold last", 32'(s1.last), 32'(prev_last));
        end
        if (s1.valid && s1.ready) begin
          if (q1.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected beat: got data %0b expected none at %0t", s1.data, $time);
          end else begin
            e = q1.pop_front();
            chk("beat data", 32'(s1.data), 32'(e.data));
            chk("beat last", 32'(s1.last), 32'(e.last));
          end
        end
        if (done) begin
          n_cmp++;
          if (exp_done1 == 0) begin
            n_err++;
            $display("FAIL unexpected done: got 1 expected 0 at %0t", $time);
          end else begin
            exp_done1--;
          end
        end
        prev_stall = s1.valid && !s1.ready;
        prev_data  = s1.data;
        prev_last  = s1.last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Monitor for the WIDTH=2 instance.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (clear && s2.valid && s2.ready) begin
        if (q2.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL w2 unexpected beat: got data %0b expected none at %0t", s2.data, $time);
        end else begin
          e = q2.pop_front();
          chk("w2 beat data", 32'(s2.data), 32'(e.data));
          chk("w2 beat last", 32'(s2.last), 32'(e.last));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  localparam logic [3:0] ReadyPat = 4'b1001;  // index 0 first: 1,0,0,1

  initial begin
    int last_c;
    int nd;
    clear        = 1'b0;
    capture_req  = 1'b0;
    state_in     = 8'h00;
    capture_req2 = 1'b0;
    state_in2    = 2'b00;
    s1.ready     = 1'b1;
    s2.ready     = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst valid", 32'(s1.valid), 32'd0);
    chk("rst data", 32'(s1.data), 32'd0);
    chk("rst last", 32'(s1.last), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    clear = 1'b1;
    @(posedge clk);
    #1;

    // 1: A5 at full rate, exact timing
    push8(8'hA5, 1'b0, 1'b1);
    capture8(8'hA5);
    for (int i = 0; i < Beats8; i++) begin
      @(negedge clk);
      chk("t1 valid", 32'(s1.valid), 32'd1);
    end
    @(negedge clk);
    chk("t1 done", 32'(done), 32'd1);
    chk("t1 done valid", 32'(s1.valid), 32'd0);
    chk("t1 done busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t1 idle busy", 32'(busy), 32'd0);
    chk("t1 idle done", 32'(done), 32'd0);
    @(posedge clk);
    #1;

    // 2: 3C with ready toggling 1,0,0,1,...
    push8(8'h3C, 1'b0, 1'b1);
    capture8(8'h3C);
    for (int k = 0; k < 80 && !done; k++) begin
      s1.ready = ReadyPat[k % 4];
      @(posedge clk);
      #1;
    end
    chk("t2 done seen", 32'(done), 32'd1);
    s1.ready = 1'b1;
    wait_idle("t2 idle");
    @(posedge clk);
    #1;

    // 3: F0, state_in changes and a second request arrives during beat 3
    push8(8'hF0, 1'b0, 1'b1);
    capture8(8'hF0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    state_in    = 8'h0F;
    capture_req = 1'b1;
    @(posedge clk);
    #1 capture_req = 1'b0;
    wait_idle("t3 idle");
    repeat (4) begin
      @(negedge clk);
      chk("t3 no restart", 32'(s1.valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // 4: reset during beat 4 of 6B; only beats 1-3 transfer
    q1.push_back('{data: 1'b1, last: 1'b0});
    q1.push_back('{data: 1'b1, last: 1'b0});
    q1.push_back('{data: 1'b0, last: 1'b0});
    capture8(8'h6B);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    clear = 1'b0;
    #1;
    chk("t4 rst busy", 32'(busy), 32'd0);
    chk("t4 rst valid", 32'(s1.valid), 32'd0);
    chk("t4 rst data", 32'(s1.data), 32'd0);
    chk("t4 rst last", 32'(s1.last), 32'd0);
    chk("t4 rst done", 32'(done), 32'd0);
    @(negedge clk);
    clear = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("t4 stays idle", 32'(s1.valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // 5: parity vectors (parity beat only present with the macro defined)
    push8(8'hA5, 1'b0, 1'b1);
    capture8(8'hA5);
    wait_idle("t5a idle");
    @(posedge clk);
    #1;
    push8(8'h07, 1'b1, 1'b1);
    capture8(8'h07);
    wait_idle("t5b idle");
    @(posedge clk);
    #1;

    // 6: WIDTH=2, request held high; done pulses spaced BEATS+2 cycles apart
    for (int s = 0; s < 3; s++) begin
      q2.push_back('{data: 1'b1, last: 1'b0});
      q2.push_back('{data: 1'b0, last: !ParEn});
      if (ParEn) q2.push_back('{data: 1'b1, last: 1'b1});
    end
    state_in2    = 2'b01;
    capture_req2 = 1'b1;
    last_c = 0;
    nd     = 0;
    for (int c = 0; c < 60 && nd < 3; c++) begin
      @(negedge clk);
      if (done2) begin
        if (nd > 0) chk("w2 done spacing", 32'(c - last_c), 32'(Beats2 + 2));
        last_c = c;
        nd++;
        if (nd == 3) capture_req2 = 1'b0;
      end
    end
    chk("w2 done count", 32'(nd), 32'd3);
    repeat (6) @(negedge clk);
    chk("w2 idle", 32'(busy2), 32'd0);

    chk("q1 drained", 32'(q1.size()), 32'd0);
    chk("q2 drained", 32'(q2.size()), 32'd0);
    chk("done pending", 32'(exp_done1), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
